// File: rtl/sva_result_collector.sv
// Collects pass/fail/lazy results of an assertion checker over a start/stop run.
// Optional fail-stamp FIFO is built only when SVA_COLLECT_FIFO_EN is defined.
module sva_result_collector #(
  parameter int CNT_WIDTH   = 16,
  parameter int STAMP_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   eval_valid,
  input  logic                   succ,
  input  logic                   fail,
  input  logic                   lazy_succ,
  input  logic [STAMP_WIDTH-1:0] stamp,
  output logic [CNT_WIDTH-1:0]   succ_cnt,
  output logic [CNT_WIDTH-1:0]   fail_cnt,
  output logic [CNT_WIDTH-1:0]   lazy_cnt,
  output logic                   first_fail_valid,
  output logic [STAMP_WIDTH-1:0] first_fail_stamp,
  output logic [1:0]             state,
  output logic                   verdict_pass,
  output logic                   verdict_fail,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [STAMP_WIDTH-1:0] rd_stamp,
  output logic                   ovf
);

  // state | meaning
  // IDLE  | no run since reset
  // RUN   | collecting evaluations
  // DONE  | run stopped, results and verdict held
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t st;
  logic   counting;

  // start wins in every state, so evaluations on a start cycle are never counted
  assign counting = (st == RUN) && eval_valid && !start;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st               <= IDLE;
      succ_cnt         <= '0;
      fail_cnt         <= '0;
      lazy_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_stamp <= '0;
    end else if (start) begin
      st               <= RUN;
      succ_cnt         <= '0;
      fail_cnt         <= '0;
      lazy_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_stamp <= '0;
    end else begin
      if (stop && st == RUN) st <= DONE;
      if (counting) begin
        if (succ && succ_cnt != CNT_MAX)      succ_cnt <= succ_cnt + CNT_ONE;
        if (fail && fail_cnt != CNT_MAX)      fail_cnt <= fail_cnt + CNT_ONE;
        if (lazy_succ && lazy_cnt != CNT_MAX) lazy_cnt <= lazy_cnt + CNT_ONE;
        if (fail && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_stamp <= stamp;
        end
      end
    end
  end

  assign state        = st;
  assign verdict_fail = (st == DONE) && (fail_cnt != '0);
  assign verdict_pass = (st == DONE) && (fail_cnt == '0) && ((succ_cnt | lazy_cnt) != '0);

`ifdef SVA_COLLECT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [STAMP_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            fill;
  logic                   push, pop, full, do_push;

  assign push    = counting && fail;
  assign pop     = rd_valid && rd_ready;
  assign full    = (fill == FULL_LVL);
  // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
  assign do_push = push && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (do_push && !sys_rst && !start) mem[wr_ptr] <= stamp;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      fill <= fill + (AW+1)'(1);
      else if (pop && !do_push) fill <= fill - (AW+1)'(1);
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  assign rd_valid = (fill != '0);
  assign rd_stamp = rd_valid ? mem[rd_ptr] : '0;
`else
  logic unused_rd_ready;
  assign unused_rd_ready = rd_ready;
  assign rd_valid        = 1'b0;
  assign rd_stamp        = '0;
  assign ovf             = 1'b0;
`endif

endmodule

// File: tb/tb_sva_result_collector.sv
// Directed bench for sva_result_collector; a second instance with CNT_WIDTH=2 checks saturation.
module tb_sva_result_collector;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, stop, eval_valid, succ, fail, lazy_succ, rd_ready;
  logic [7:0]  stamp;

  logic [15:0] succ_cnt, fail_cnt, lazy_cnt;
  logic        first_fail_valid, verdict_pass, verdict_fail, rd_valid, ovf;
  logic [7:0]  first_fail_stamp, rd_stamp;
  logic [1:0]  state;

  logic [1:0]  sat_succ_cnt, sat_fail_cnt, sat_lazy_cnt;
  logic        sat_ffv, sat_pass, sat_fail, sat_rd_valid, sat_ovf;
  logic [7:0]  sat_ffs, sat_rd_stamp;
  logic [1:0]  sat_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_a [4];

  always #5 sys_clk = ~sys_clk;

  sva_result_collector #(.CNT_WIDTH(16), .STAMP_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .eval_valid(eval_valid), .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .stamp(stamp), .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_stamp(first_fail_stamp),
    .state(state), .verdict_pass(verdict_pass), .verdict_fail(verdict_fail),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_stamp(rd_stamp), .ovf(ovf)
  );

  sva_result_collector #(.CNT_WIDTH(2), .STAMP_WIDTH(8), .FIFO_DEPTH(4)) dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .eval_valid(eval_valid), .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .stamp(stamp), .succ_cnt(sat_succ_cnt), .fail_cnt(sat_fail_cnt), .lazy_cnt(sat_lazy_cnt),
    .first_fail_valid(sat_ffv), .first_fail_stamp(sat_ffs),
    .state(sat_state), .verdict_pass(sat_pass), .verdict_fail(sat_fail),
    .rd_valid(sat_rd_valid), .rd_ready(rd_ready), .rd_stamp(sat_rd_stamp), .ovf(sat_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic do_eval(input logic s, input logic f, input logic l, input logic [7:0] t);
    eval_valid = 1'b1;
    succ       = s;
    fail       = f;
    lazy_succ  = l;
    stamp      = t;
    cycle();
    eval_valid = 1'b0;
    succ       = 1'b0;
    fail       = 1'b0;
    lazy_succ  = 1'b0;
    stamp      = '0;
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; eval_valid = 1'b0;
    succ = 1'b0; fail = 1'b0; lazy_succ = 1'b0; stamp = '0; rd_ready = 1'b0;
    cycle();
    cycle();
    sys_rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_succ", 32'(succ_cnt), 0);
    chk("rst_ffv", 32'(first_fail_valid), 0);
    chk("rst_verdict", 32'({verdict_pass, verdict_fail}), 0);
    chk("rst_fifo", 32'({rd_valid, ovf}), 0);

    // idle ignores evaluations and stop
    do_eval(1, 1, 1, 8'd3);
    pulse_stop();
    chk("idle_state", 32'(state), 0);
    chk("idle_cnt", 32'(succ_cnt + fail_cnt + lazy_cnt), 0);

    // simple passing run
    pulse_start();
    chk("run_state", 32'(state), 1);
    repeat (3) do_eval(1, 0, 0, 8'd0);
    pulse_stop();
    chk("pass_state", 32'(state), 2);
    chk("pass_succ", 32'(succ_cnt), 3);
    chk("pass_vpass", 32'(verdict_pass), 1);
    chk("pass_vfail", 32'(verdict_fail), 0);
    do_eval(1, 1, 0, 8'd1);
    chk("done_hold_succ", 32'(succ_cnt), 3);
    chk("done_hold_fail", 32'(fail_cnt), 0);

    // vacuous run, restarted from DONE
    pulse_start();
    chk("restart_state", 32'(state), 1);
    chk("restart_succ", 32'(succ_cnt), 0);
    pulse_stop();
    chk("vac_state", 32'(state), 2);
    chk("vac_verdict", 32'({verdict_pass, verdict_fail}), 0);

    // failing run; last fail arrives together with stop
    pulse_start();
    do_eval(0, 1, 0, 8'd5);
    do_eval(1, 0, 0, 8'd7);
    do_eval(0, 1, 0, 8'd9);
    stop = 1'b1;
    do_eval(0, 1, 0, 8'd12);
    stop = 1'b0;
    chk("ff_state", 32'(state), 2);
    chk("ff_fail_cnt", 32'(fail_cnt), 3);
    chk("ff_succ_cnt", 32'(succ_cnt), 1);
    chk("ff_valid", 32'(first_fail_valid), 1);
    chk("ff_stamp", 32'(first_fail_stamp), 5);
    chk("ff_verdict", 32'({verdict_pass, verdict_fail}), 1);
`ifdef SVA_COLLECT_FIFO_EN
    exp_a[0] = 8'd5; exp_a[1] = 8'd9; exp_a[2] = 8'd12; exp_a[3] = 8'd0;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ff_rd_valid", 32'(rd_valid), 1);
      chk("ff_rd_stamp", 32'(rd_stamp), 32'(exp_a[i]));
      cycle();
    end
    rd_ready = 1'b0;
    chk("ff_empty", 32'({rd_valid, rd_stamp}), 0);
`else
    chk("nofifo_rd", 32'({rd_valid, rd_stamp}), 0);
`endif

    // FIFO full behaviour
    pulse_start();
    for (int i = 1; i <= 4; i++) do_eval(0, 1, 0, 8'(i));
`ifdef SVA_COLLECT_FIFO_EN
    chk("full_ovf0", 32'(ovf), 0);
    chk("full_head", 32'(rd_stamp), 1);
    rd_ready = 1'b1;
    do_eval(0, 1, 0, 8'd5);
    rd_ready = 1'b0;
    chk("pushpop_ovf0", 32'(ovf), 0);
    chk("pushpop_head", 32'(rd_stamp), 2);
    exp_a[0] = 8'd2; exp_a[1] = 8'd3; exp_a[2] = 8'd4; exp_a[3] = 8'd5;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_a", 32'(rd_stamp), 32'(exp_a[i]));
      cycle();
    end
    rd_ready = 1'b0;
    chk("drain_a_empty", 32'(rd_valid), 0);
`else
    do_eval(0, 1, 0, 8'd5);
`endif
    chk("full_fail_cnt", 32'(fail_cnt), 5);

    pulse_start();
    for (int i = 10; i <= 15; i++) do_eval(0, 1, 0, 8'(i));
    chk("ovf_fail_cnt", 32'(fail_cnt), 6);
`ifdef SVA_COLLECT_FIFO_EN
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_head", 32'(rd_stamp), 10);
    rd_ready = 1'b1;
    do_eval(0, 1, 0, 8'd20);
    rd_ready = 1'b0;
    chk("ovf_held", 32'(ovf), 1);
    exp_a[0] = 8'd11; exp_a[1] = 8'd12; exp_a[2] = 8'd13; exp_a[3] = 8'd20;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_b", 32'(rd_stamp), 32'(exp_a[i]));
      cycle();
    end
    rd_ready = 1'b0;
    chk("drain_b_empty", 32'(rd_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    pulse_start();
    chk("ovf_cleared", 32'(ovf), 0);
`else
    chk("nofifo_ovf", 32'({ovf, rd_valid}), 0);
    pulse_start();
`endif

    // saturation: both counters bump together
    repeat (5) do_eval(1, 0, 1, 8'd0);
    pulse_stop();
    chk("sat_wide_succ", 32'(succ_cnt), 5);
    chk("sat_wide_lazy", 32'(lazy_cnt), 5);
    chk("sat_succ", 32'(sat_succ_cnt), 3);
    chk("sat_lazy", 32'(sat_lazy_cnt), 3);
    chk("sat_vpass", 32'(sat_pass), 1);

    // start and stop together in RUN restarts
    pulse_start();
    do_eval(1, 0, 0, 8'd0);
    do_eval(1, 0, 0, 8'd0);
    start = 1'b1;
    stop  = 1'b1;
    do_eval(1, 1, 0, 8'd4);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_state", 32'(state), 1);
    chk("ss_succ", 32'(succ_cnt), 0);
    chk("ss_fail", 32'(fail_cnt), 0);
    do_eval(1, 0, 0, 8'd0);
    do_eval(0, 1, 1, 8'd7);
    chk("ss_after", 32'({succ_cnt[3:0], fail_cnt[3:0], lazy_cnt[3:0]}), 32'h111);

    // reset mid-run beats start/eval
    sys_rst = 1'b1;
    start   = 1'b1;
    do_eval(1, 1, 1, 8'd9);
    sys_rst = 1'b0;
    start   = 1'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_cnt", 32'(succ_cnt | fail_cnt | lazy_cnt), 0);
    chk("mid_rst_ff", 32'({first_fail_valid, first_fail_stamp}), 0);
    chk("mid_rst_misc", 32'({verdict_pass, verdict_fail, rd_valid, rd_stamp, ovf}), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
